// File: rtl/pc_pkg.sv
// Shared types and default constants for the next-PC generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int          DEF_XLEN      = 16;
    localparam int          DEF_INC       = 4;
    localparam int          DEF_RAS_DEPTH = 4;
    localparam int          ALIGN_BITS    = $clog2(DEF_INC);
    localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
    localparam logic [15:0] DEF_TRAP_VEC  = 16'h0010;

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: saturating count, oldest entry overwritten.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               top,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign top    = mem[ptr];
    assign do_pop = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_pop && push) begin
            // pop-then-push collapses to replacing the top in place
            mem[ptr] <= push_data;
        end else if (push) begin
            mem[ptr + PW'(1)] <= push_data;
            ptr               <= ptr + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (do_pop) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: boot/run/halt FSM, prioritised trap/redirect mux,
// alignment check and return-address prediction.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter int              INC       = DEF_INC,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            resume_i,
    input  logic            trap_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misalign_o,
    output logic            ras_underflow_o,
    output logic            ras_empty_o
);

    localparam int              CW       = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] LSB_MASK = XLEN'(INC - 1);

    pc_state_t       state, state_n;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] inc_pc;
    logic [XLEN-1:0] rd_align;
    logic            rd_mis;
    logic            mis_n;
    logic            und_n;
    logic            in_run;
    logic            in_halt;
    logic            ras_clr;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic [CW-1:0]   ras_count;

    assign in_run   = (state == RUN);
    assign in_halt  = (state == HALT);
    assign inc_pc   = pc_o + XLEN'(INC);
    assign rd_align = redirect_pc_i & ~LSB_MASK;
    assign rd_mis   = |(redirect_pc_i & LSB_MASK);

    // A call pushes even when its target arrives on the redirect path.
    assign ras_clr  = trap_i && (in_run || in_halt);
    assign ras_push = in_run && call_i && !stall_i && !trap_i;
    assign ras_pop  = in_run && ret_i && !stall_i && !trap_i && !redirect_i;

    always_comb begin
        state_n = state;
        pc_n    = pc_o;
        mis_n   = 1'b0;
        und_n   = 1'b0;
        unique case (state)
            BOOT: begin
                state_n = RUN;
            end
            RUN: begin
                if (trap_i) begin
                    pc_n = TRAP_VEC;
                end else if (redirect_i) begin
                    pc_n  = rd_align;
                    mis_n = rd_mis;
                end else if (stall_i) begin
                    pc_n = pc_o;
                end else if (ret_i && !ras_empty_o) begin
                    pc_n = ras_top;
                end else begin
                    pc_n  = inc_pc;
                    und_n = ret_i;
                end
                if (halt_i && !trap_i) begin
                    state_n = HALT;
                end
            end
            HALT: begin
                if (trap_i) begin
                    pc_n    = TRAP_VEC;
                    state_n = RUN;
                end else begin
                    if (redirect_i) begin
                        pc_n  = rd_align;
                        mis_n = rd_mis;
                    end
                    if (resume_i && !halt_i) begin
                        state_n = RUN;
                    end
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= BOOT;
            pc_o            <= RESET_VEC;
            pc_valid_o      <= 1'b0;
            misalign_o      <= 1'b0;
            ras_underflow_o <= 1'b0;
        end else begin
            state           <= state_n;
            pc_o            <= pc_n;
            pc_valid_o      <= (state_n == RUN);
            misalign_o      <= mis_n;
            ras_underflow_o <= und_n;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ras_clr),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (inc_pc),
        .top       (ras_top),
        .empty     (ras_empty_o),
        .count     (ras_count)
    );

endmodule
